esfa_vector_loader: RTL

- Upstream stage of the ESFA self-test harness.
- Receives test vectors as a byte stream with a valid/ready handshake, and assembles each group of 8 bytes into one 64-bit vector.
- Writes each vector into the vector memory consumed by the ESFA test sequencer, at byte address `8 × index`.
- Stops at the end-of-program vector, or when capacity is exhausted, and reports completion, error and vector count.

---
 rtl/esfa_vector_loader_if.sv | 24 ++
 rtl/esfa_vector_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/esfa_vector_loader_if.sv
// Byte-stream input, vector-memory write port and load status of the ESFA
// vector loader. The loader is the slave; whoever feeds it is the master.
interface esfa_vector_loader_if;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWe;
  logic [31:0] memAddr;
  logic [63:0] memData;
  logic        loadDone;
  logic        loadError;
  logic [15:0] vectorCount;

  modport master (
    output start, byteIn, byteValid,
    input  byteReady, memWe, memAddr, memData, loadDone, loadError, vectorCount
  );

  modport slave (
    input  start, byteIn, byteValid,
    output byteReady, memWe, memAddr, memData, loadDone, loadError, vectorCount
  );
endinterface

// File: rtl/esfa_vector_loader.sv
// ESFA vector loader: packs a little-endian byte stream into 64-bit test
// vectors and writes them to the sequencer's vector memory at 8*index,
// stopping on the end-of-program flag (byte 0, bit 2) or when memory is full.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RECV  | collecting the bytes of one vector
// WRITE | single cycle with memWe high
// DONE  | load finished (loadDone high), waiting for start
module esfa_vector_loader #(
  parameter int MAX_VECTORS = 256
) (
  input logic clk,
  input logic reset,
  esfa_vector_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [15:0] MaxCount = 16'(MAX_VECTORS);

  state_t          state;
  state_t          nextState;
  logic [2:0]      byteIdx;
  logic [6:0][7:0] assembly;
  logic            memWe;
  logic [31:0]     memAddr;
  logic [63:0]     memData;
  logic            loadDone;
  logic            loadError;
  logic [15:0]     vectorCount;
  logic [15:0]     countInc;
  logic            byteReady;
  logic            xfer;

  assign byteReady = (state == RECV) && !bus.start;
  assign xfer      = bus.byteValid && byteReady;
  assign countInc  = vectorCount + 16'd1;

  assign bus.byteReady   = byteReady;
  assign bus.memWe       = memWe;
  assign bus.memAddr     = memAddr;
  assign bus.memData     = memData;
  assign bus.loadDone    = loadDone;
  assign bus.loadError   = loadError;
  assign bus.vectorCount = vectorCount;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: start restarts from any state; the end flag wins over a full memory.
  always_comb begin
    nextState = state;
    if (bus.start) begin
      nextState = RECV;
    end else begin
      unique case (state)
        IDLE:  nextState = IDLE;
        RECV:  if (xfer && byteIdx == 3'd7) nextState = WRITE;
        WRITE: begin
          if (memData[2] || countInc == MaxCount) nextState = DONE;
          else                                    nextState = RECV;
        end
        DONE:  nextState = DONE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Datapath: byte assembly, write strobe/address/data and load status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byteIdx     <= '0;
      assembly    <= '0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memData     <= '0;
      loadDone    <= 1'b0;
      loadError   <= 1'b0;
      vectorCount <= '0;
    end else if (bus.start) begin
      // An interrupted write has already been strobed; only the bookkeeping is dropped.
      byteIdx     <= '0;
      assembly    <= '0;
      memWe       <= 1'b0;
      loadDone    <= 1'b0;
      loadError   <= 1'b0;
      vectorCount <= '0;
    end else begin
      unique case (state)
        RECV: begin
          if (xfer) begin
            byteIdx <= byteIdx + 3'd1;
            if (byteIdx == 3'd7) begin
              memWe   <= 1'b1;
              memAddr <= {13'd0, vectorCount, 3'd0};
              memData <= {bus.byteIn, assembly};
            end else begin
              assembly[byteIdx] <= bus.byteIn;
            end
          end
        end
        WRITE: begin
          memWe       <= 1'b0;
          byteIdx     <= '0;
          vectorCount <= countInc;
          if (memData[2]) begin
            loadDone <= 1'b1;
          end else if (countInc == MaxCount) begin
            loadDone  <= 1'b1;
            loadError <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
